// File: rtl/bcd_op_pkg.sv
// ============================================================================
// Module  : bcd_op_pkg
// Brief   : Shared state encoding, digit types and decimal constants for the
//           digit-serial BCD operating unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_op_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SUM   = 3'd2,
        ST_CHECK = 3'd3,
        ST_INC_C = 3'd4,
        ST_PLUS6 = 3'd5,
        ST_INC_S = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [4:0] wide_digit_t;

    localparam wide_digit_t BCD_LIMIT = 5'd10;
    localparam bcd_digit_t  BCD_CORR  = 4'd6;

endpackage

`default_nettype wire

// File: rtl/bcd_op_ctrl.sv
// ============================================================================
// Module  : bcd_op_ctrl
// Brief   : Control FSM of the BCD operating unit; every output flag is a
//           register loaded from the next-state decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_op_ctrl
    import bcd_op_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_x1,
    input  logic i_x2,
    input  logic i_x3,
    output logic o_add,
    output logic o_state_wait,
    output logic o_state_load,
    output logic o_state_sum,
    output logic o_state_inc_c,
    output logic o_state_plus_6_c,
    output logic o_state_inc_s,
    output logic o_done
);

    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_SUM   = ST_SUM;
    localparam logic [2:0] S_CHECK = ST_CHECK;
    localparam logic [2:0] S_INC_C = ST_INC_C;
    localparam logic [2:0] S_PLUS6 = ST_PLUS6;
    localparam logic [2:0] S_INC_S = ST_INC_S;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_wait, r_load, r_add, r_sum_grp, r_inc_c, r_plus6, r_inc_s, r_done;

    always_comb begin
        w_next = S_WAIT;
        case (r_state)
            S_WAIT:  w_next = i_start ? S_LOAD : S_WAIT;
            S_LOAD:  w_next = S_SUM;
            S_SUM:   w_next = S_CHECK;
            S_CHECK: w_next = (i_x2 || i_x3) ? S_INC_C : S_INC_S;
            S_INC_C: w_next = S_PLUS6;
            S_PLUS6: w_next = S_INC_S;
            S_INC_S: w_next = i_x1 ? S_SUM : S_DONE;
            S_DONE:  w_next = S_WAIT;
            default: w_next = S_WAIT;
        endcase
    end

    // SUM and CHECK share the externally visible sum flag; r_add marks SUM only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_WAIT;
            r_wait    <= 1'b1;
            r_load    <= 1'b0;
            r_add     <= 1'b0;
            r_sum_grp <= 1'b0;
            r_inc_c   <= 1'b0;
            r_plus6   <= 1'b0;
            r_inc_s   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wait    <= (w_next == S_WAIT);
            r_load    <= (w_next == S_LOAD);
            r_add     <= (w_next == S_SUM);
            r_sum_grp <= (w_next == S_SUM) || (w_next == S_CHECK);
            r_inc_c   <= (w_next == S_INC_C);
            r_plus6   <= (w_next == S_PLUS6);
            r_inc_s   <= (w_next == S_INC_S);
            r_done    <= (w_next == S_DONE);
        end
    end

    assign o_add            = r_add;
    assign o_state_wait     = r_wait;
    assign o_state_load     = r_load;
    assign o_state_sum      = r_sum_grp;
    assign o_state_inc_c    = r_inc_c;
    assign o_state_plus_6_c = r_plus6;
    assign o_state_inc_s    = r_inc_s;
    assign o_done           = r_done;

endmodule

`default_nettype wire

// File: rtl/bcd_operating_unit.sv
// ============================================================================
// Module  : bcd_operating_unit
// Brief   : Sequential N-digit BCD adder (digit-serial datapath + control FSM).
//           Optional define OVERFLOW_EN adds the ovf carry-out flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_operating_unit
    import bcd_op_pkg::*;
#(
    parameter int N = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A_in [N],
    input  logic [3:0] B_in [N],
    output logic [4:0] C [N],
    output logic [3:0] s,
    output logic       done,
    output logic       state_wait,
    output logic       state_load,
    output logic       state_sum,
    output logic       state_inc_c,
    output logic       state_plus_6_c,
    output logic       state_inc_s
`ifdef OVERFLOW_EN
    ,
    output logic       ovf
`endif
);

    localparam logic [3:0] c_LAST = 4'(N - 1);
    localparam logic [4:0] c_NDIG = 5'(N);

    wide_digit_t r_c [N];
    logic [3:0]  r_s;
    logic [3:0]  w_k;
    wide_digit_t w_ck;
    logic        w_x1, w_x2, w_x3;
    logic        w_add, w_load, w_inc_c, w_plus6, w_inc_s;

    assign w_k = c_LAST - r_s;

    always_comb begin
        w_ck = '0;
        for (int i = 0; i < N; i++) begin
            if (4'(i) == w_k) w_ck = r_c[i];
        end
    end

    // x1 is judged in INC_S, so it looks at the count after this digit
    assign w_x1 = (({1'b0, r_s} + 5'd1) < c_NDIG);
    assign w_x2 = w_ck[4];
    assign w_x3 = (w_ck >= BCD_LIMIT) && !w_ck[4];

    bcd_op_ctrl u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .i_start          (start),
        .i_x1             (w_x1),
        .i_x2             (w_x2),
        .i_x3             (w_x3),
        .o_add            (w_add),
        .o_state_wait     (state_wait),
        .o_state_load     (w_load),
        .o_state_sum      (state_sum),
        .o_state_inc_c    (w_inc_c),
        .o_state_plus_6_c (w_plus6),
        .o_state_inc_s    (w_inc_s),
        .o_done           (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) r_c[i] <= '0;
            r_s <= '0;
        end else begin
            if (w_load) begin
                for (int i = 0; i < N; i++) r_c[i] <= {1'b0, A_in[i]};
                r_s <= '0;
            end
            for (int i = 0; i < N; i++) begin
                if (w_add && (4'(i) == w_k))
                    r_c[i] <= r_c[i] + {1'b0, B_in[i]};
                if (w_inc_c && ((4'(i) + 4'd1) == w_k))
                    r_c[i] <= r_c[i] + 5'd1;
                if (w_plus6 && (4'(i) == w_k))
                    r_c[i] <= {1'b0, r_c[i][3:0] + BCD_CORR};
            end
            if (w_inc_s) r_s <= r_s + 4'd1;
        end
    end

`ifdef OVERFLOW_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        r_ovf <= 1'b0;
        else if (w_load)                 r_ovf <= 1'b0;
        else if (w_inc_c && w_k == 4'd0) r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

    assign C              = r_c;
    assign s              = r_s;
    assign state_load     = w_load;
    assign state_inc_c    = w_inc_c;
    assign state_plus_6_c = w_plus6;
    assign state_inc_s    = w_inc_s;

endmodule

`default_nettype wire

// File: tb/tb_bcd_operating_unit.sv
// ============================================================================
// Module  : tb_bcd_operating_unit
// Brief   : Scoreboard bench for bcd_operating_unit (N=5); honours OVERFLOW_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_operating_unit;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A_in [N];
    logic [3:0] B_in [N];
    logic [4:0] C [N];
    logic [3:0] s;
    logic       done, state_wait, state_load, state_sum;
    logic       state_inc_c, state_plus_6_c, state_inc_s;
`ifdef OVERFLOW_EN
    logic       ovf;
`endif

    // Operands/results are packed with digit 0 in the top nibble, so 20'h36189 = {3,6,1,8,9}
    typedef struct packed {
        logic [19:0] dig;
        logic        ovf;
        logic [7:0]  lat;
        logic [3:0]  ncorr;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   corr_seen = 0;
    int   n_done = 0;

    bcd_operating_unit #(.N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .A_in           (A_in),
        .B_in           (B_in),
        .C              (C),
        .s              (s),
        .done           (done),
        .state_wait     (state_wait),
        .state_load     (state_load),
        .state_sum      (state_sum),
        .state_inc_c    (state_inc_c),
        .state_plus_6_c (state_plus_6_c),
        .state_inc_s    (state_inc_s)
`ifdef OVERFLOW_EN
        ,
        .ovf            (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain decimal ripple addition; latency counts LOAD as cycle 0 up to DONE
    function automatic exp_t model(input logic [19:0] a, input logic [19:0] b);
        exp_t r;
        int   t;
        int   carry = 0;
        r     = '0;
        r.lat = 8'd1;
        for (int k = N - 1; k >= 0; k--) begin
            t = int'(a[4*(N-1-k) +: 4]) + int'(b[4*(N-1-k) +: 4]) + carry;
            if (t >= 10) begin
                r.dig[4*(N-1-k) +: 4] = 4'(t - 10);
                carry   = 1;
                r.ncorr = r.ncorr + 4'd1;
                r.lat   = r.lat + 8'd5;
            end else begin
                r.dig[4*(N-1-k) +: 4] = 4'(t);
                carry = 0;
                r.lat = r.lat + 8'd3;
            end
        end
        r.ovf = (carry != 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check_eq("onehot", $countones({state_wait, state_load, state_sum, state_inc_c,
                                           state_plus_6_c, state_inc_s, done}), 1);
            if (state_load) begin
                cyc       = 0;
                corr_seen = 0;
            end else begin
                cyc++;
            end
            if (state_inc_c) corr_seen++;
            if (done) begin
                check_eq("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e_cur = sb_q.pop_front();
                    check_eq("latency", cyc, e_cur.lat);
                    check_eq("n_corr", corr_seen, e_cur.ncorr);
                    check_eq("s_final", s, N);
                    for (int i = 0; i < N; i++)
                        check_eq($sformatf("C[%0d]", i), C[i], {1'b0, e_cur.dig[4*(N-1-i) +: 4]});
`ifdef OVERFLOW_EN
                    check_eq("ovf", ovf, e_cur.ovf);
`endif
                end
                n_done++;
            end
        end
    end

    task automatic set_ops(input logic [19:0] a, input logic [19:0] b);
        for (int i = 0; i < N; i++) begin
            A_in[i] = a[4*(N-1-i) +: 4];
            B_in[i] = b[4*(N-1-i) +: 4];
        end
    endtask

    task automatic wait_done(input string tag);
        int target = n_done + 1;
        int i = 0;
        while (n_done < target && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_eq(tag, n_done >= target, 1);
    endtask

    task automatic run(input logic [19:0] a, input logic [19:0] b);
        set_ops(a, b);
        sb_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_timeout");
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wait"}, state_wait, 1);
        check_eq({tag, "_others"}, {state_load, state_sum, state_inc_c, state_plus_6_c,
                                    state_inc_s, done}, 0);
        check_eq({tag, "_s"}, s, 0);
        for (int i = 0; i < N; i++) check_eq($sformatf("%s_C[%0d]", tag, i), C[i], 0);
`ifdef OVERFLOW_EN
        check_eq({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    initial begin
        int found;
        set_ops(20'h0, 20'h0);
        #12;
        check_reset_state("rst");
        @(negedge clk);
        rst = 1'b1;

        run(20'h36189, 20'h07083);
        run(20'h00005, 20'h00004);
        run(20'h09999, 20'h00001);
        run(20'h90000, 20'h90000);

        // Abandon a run at the INC_C of digit 2 (s == 2)
        set_ops(20'h00500, 20'h00500);
        sb_q.push_back(model(20'h00500, 20'h00500));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (state_inc_c && s == 4'd2) found = 1;
        end
        check_eq("midrun_reach", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("midrun");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run(20'h00500, 20'h00500);

        // start held high across a whole run and through DONE
        set_ops(20'h12345, 20'h54321);
        sb_q.push_back(model(20'h12345, 20'h54321));
        sb_q.push_back(model(20'h12345, 20'h54321));
        @(negedge clk);
        start = 1'b1;
        wait_done("held_done1");
        @(negedge clk);
        #1;
        check_eq("held_wait", state_wait, 1);
        @(negedge clk);
        #1;
        check_eq("held_reload", state_load, 1);
        start = 1'b0;
        wait_done("held_done2");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
